// File: rtl/rvc_expander_pkg.sv
// Shared encodings for the RVC expander: RV32I opcodes/funct3, RVC quadrant and funct3 codes.
// Pure declarations; no latency or flow control.
package rvc_expander_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_SR  = 3'b101;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    typedef enum logic [1:0] {
        QUAD0     = 2'b00,
        QUAD1     = 2'b01,
        QUAD2     = 2'b10,
        QUAD_FULL = 2'b11
    } rvc_quad_e;

    localparam logic [2:0] C0_ADDI4SPN = 3'b000;
    localparam logic [2:0] C0_LW       = 3'b010;
    localparam logic [2:0] C0_SW       = 3'b110;
    localparam logic [2:0] C1_ADDI     = 3'b000;
    localparam logic [2:0] C1_JAL      = 3'b001;
    localparam logic [2:0] C1_LI       = 3'b010;
    localparam logic [2:0] C1_LUI      = 3'b011;
    localparam logic [2:0] C1_ARITH    = 3'b100;
    localparam logic [2:0] C1_J        = 3'b101;
    localparam logic [2:0] C1_BEQZ     = 3'b110;
    localparam logic [2:0] C1_BNEZ     = 3'b111;
    localparam logic [2:0] C2_SLLI     = 3'b000;
    localparam logic [2:0] C2_LWSP     = 3'b010;
    localparam logic [2:0] C2_JR_MV    = 3'b100;
    localparam logic [2:0] C2_SWSP     = 3'b110;

    // Compressed 3-bit register fields address x8..x15.
    function automatic logic [4:0] creg(input logic [2:0] f);
        return {2'b01, f};
    endfunction

endpackage

// File: rtl/rvc_decompress.sv
// Combinational RV32C -> RV32I expander; illegal/unsupported encodings yield NOP_WORD with o_illegal set.
// Zero latency, no flow control.
module rvc_decompress
    import rvc_expander_pkg::*;
#(
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic [15:0] i_c,
    output logic [31:0] o_inst,
    output logic        o_illegal
);

    logic [2:0]  w_f3;
    logic [4:0]  w_rd, w_rs2, w_rdp, w_rs1p;
    logic [11:0] w_imm6;
    logic [11:1] w_joff;
    logic [8:1]  w_boff;
    logic [31:0] w_inst;
    logic        w_ill;
    rvc_quad_e   w_quad;

    assign w_quad = rvc_quad_e'(i_c[1:0]);
    assign w_f3   = i_c[15:13];
    assign w_rd   = i_c[11:7];
    assign w_rs2  = i_c[6:2];
    assign w_rdp  = creg(i_c[4:2]);
    assign w_rs1p = creg(i_c[9:7]);
    assign w_imm6 = {{7{i_c[12]}}, i_c[6:2]};
    assign w_joff = {i_c[12], i_c[8], i_c[10:9], i_c[6], i_c[7], i_c[2], i_c[11], i_c[5:3]};
    assign w_boff = {i_c[12], i_c[6:5], i_c[2], i_c[11:10], i_c[4:3]};

    always_comb begin
        w_inst = NOP_WORD;
        w_ill  = 1'b0;
        case (w_quad)
            QUAD0: begin
                case (w_f3)
                    C0_ADDI4SPN: begin
                        w_ill  = (i_c[12:5] == 8'd0);
                        w_inst = {2'b00, i_c[10:7], i_c[12:11], i_c[5], i_c[6], 2'b00,
                                  5'd2, F3_ADD, w_rdp, OPC_OP_IMM};
                    end
                    C0_LW: w_inst = {5'd0, i_c[5], i_c[12:10], i_c[6], 2'b00,
                                     w_rs1p, F3_W, w_rdp, OPC_LOAD};
                    C0_SW: w_inst = {5'd0, i_c[5], i_c[12], w_rdp, w_rs1p, F3_W,
                                     i_c[11:10], i_c[6], 2'b00, OPC_STORE};
                    default: w_ill = 1'b1;
                endcase
            end
            QUAD1: begin
                case (w_f3)
                    C1_ADDI: w_inst = {w_imm6, w_rd, F3_ADD, w_rd, OPC_OP_IMM};
                    C1_JAL, C1_J: w_inst = {w_joff[11], w_joff[10:1], w_joff[11], {8{w_joff[11]}},
                                            (w_f3 == C1_JAL) ? 5'd1 : 5'd0, OPC_JAL};
                    C1_LI: w_inst = {w_imm6, 5'd0, F3_ADD, w_rd, OPC_OP_IMM};
                    C1_LUI: begin
                        w_ill = (w_imm6 == 12'd0);
                        if (w_rd == 5'd2)
                            w_inst = {{3{i_c[12]}}, i_c[4:3], i_c[5], i_c[2], i_c[6], 4'b0000,
                                      5'd2, F3_ADD, 5'd2, OPC_OP_IMM};
                        else
                            w_inst = {{15{i_c[12]}}, i_c[6:2], w_rd, OPC_LUI};
                    end
                    C1_ARITH: begin
                        case (i_c[11:10])
                            2'b00: begin
                                w_ill  = i_c[12];
                                w_inst = {7'b0000000, i_c[6:2], w_rs1p, F3_SR, w_rs1p, OPC_OP_IMM};
                            end
                            2'b01: begin
                                w_ill  = i_c[12];
                                w_inst = {7'b0100000, i_c[6:2], w_rs1p, F3_SR, w_rs1p, OPC_OP_IMM};
                            end
                            2'b10: w_inst = {w_imm6, w_rs1p, F3_AND, w_rs1p, OPC_OP_IMM};
                            default: begin
                                // bit 12 set selects the RV64 word ops and reserved slots
                                w_ill = i_c[12];
                                case (i_c[6:5])
                                    2'b00:   w_inst = {7'b0100000, w_rdp, w_rs1p, F3_ADD, w_rs1p, OPC_OP};
                                    2'b01:   w_inst = {7'b0000000, w_rdp, w_rs1p, F3_XOR, w_rs1p, OPC_OP};
                                    2'b10:   w_inst = {7'b0000000, w_rdp, w_rs1p, F3_OR,  w_rs1p, OPC_OP};
                                    default: w_inst = {7'b0000000, w_rdp, w_rs1p, F3_AND, w_rs1p, OPC_OP};
                                endcase
                            end
                        endcase
                    end
                    default: w_inst = {w_boff[8], {3{w_boff[8]}}, w_boff[7:5], 5'd0, w_rs1p,
                                       (w_f3 == C1_BNEZ) ? F3_BNE : F3_BEQ,
                                       w_boff[4:1], w_boff[8], OPC_BRANCH};
                endcase
            end
            QUAD2: begin
                case (w_f3)
                    C2_SLLI: begin
                        w_ill  = i_c[12];
                        w_inst = {7'b0000000, i_c[6:2], w_rd, F3_SLL, w_rd, OPC_OP_IMM};
                    end
                    C2_LWSP: begin
                        w_ill  = (w_rd == 5'd0);
                        w_inst = {4'b0000, i_c[3:2], i_c[12], i_c[6:4], 2'b00,
                                  5'd2, F3_W, w_rd, OPC_LOAD};
                    end
                    C2_JR_MV: begin
                        if (!i_c[12]) begin
                            if (w_rs2 == 5'd0) begin
                                w_ill  = (w_rd == 5'd0);
                                w_inst = {12'd0, w_rd, F3_ADD, 5'd0, OPC_JALR};
                            end else begin
                                w_inst = {7'd0, w_rs2, 5'd0, F3_ADD, w_rd, OPC_OP};
                            end
                        end else if (w_rs2 == 5'd0) begin
                            if (w_rd == 5'd0)
                                w_inst = {12'd1, 5'd0, 3'b000, 5'd0, OPC_SYSTEM};
                            else
                                w_inst = {12'd0, w_rd, F3_ADD, 5'd1, OPC_JALR};
                        end else begin
                            w_inst = {7'd0, w_rs2, w_rd, F3_ADD, w_rd, OPC_OP};
                        end
                    end
                    C2_SWSP: w_inst = {4'b0000, i_c[8:7], i_c[12], w_rs2, 5'd2, F3_W,
                                       i_c[11:9], 2'b00, OPC_STORE};
                    default: w_ill = 1'b1;
                endcase
            end
            default: w_ill = 1'b1;
        endcase
    end

    assign o_illegal = w_ill;
    assign o_inst    = w_ill ? NOP_WORD : w_inst;

endmodule

// File: rtl/rvc_expander.sv
// Expands aligned RV32C/RV32I words into one registered slot toward decode; 1-cycle latency.
// in_ready = !out_valid | out_ready; slot holds stable while decode stalls; flush empties it.
module rvc_expander #(
    parameter bit          RVC_EN   = 1'b1,
    parameter logic [31:0] NOP_INST = rvc_expander_pkg::NOP_INST
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_data,
    output logic        in_ready,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic [31:0] out_next_pc,
    output logic        out_is_compressed,
    output logic        out_illegal
);
    import rvc_expander_pkg::*;

    logic        w_is_c, w_load, w_c_ill, w_ill;
    logic [31:0] w_c_inst, w_inst, w_next_pc;

    logic        r_valid, r_is_c, r_ill;
    logic [31:0] r_inst, r_pc, r_next_pc;

    assign w_is_c    = (rvc_quad_e'(in_data[1:0]) != QUAD_FULL);
    assign w_next_pc = in_pc + (w_is_c ? 32'd2 : 32'd4);
    assign in_ready  = !r_valid | out_ready;
    assign w_load    = in_valid & in_ready;

    rvc_decompress #(
        .NOP_WORD (NOP_INST)
    ) u_decompress (
        .i_c       (in_data[15:0]),
        .o_inst    (w_c_inst),
        .o_illegal (w_c_ill)
    );

    always_comb begin
        w_inst = in_data;
        w_ill  = 1'b0;
        if (w_is_c) begin
            w_inst = RVC_EN ? w_c_inst : NOP_INST;
            w_ill  = RVC_EN ? w_c_ill : 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_inst    <= NOP_INST;
            r_pc      <= 32'd0;
            r_next_pc <= 32'd0;
            r_is_c    <= 1'b0;
            r_ill     <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_valid   <= 1'b1;
            r_inst    <= w_inst;
            r_pc      <= in_pc;
            r_next_pc <= w_next_pc;
            r_is_c    <= w_is_c;
            r_ill     <= w_ill;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid         = r_valid;
    assign out_inst          = r_inst;
    assign out_pc            = r_pc;
    assign out_next_pc       = r_next_pc;
    assign out_is_compressed = r_is_c;
    assign out_illegal       = r_ill;

endmodule

// File: tb/tb_rvc_expander.sv
// Randomized bench for rvc_expander: a one-slot expected-output queue fed by an
// instruction-level RVC reference model (field arithmetic + RV32I encoders).
module tb_rvc_expander;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, flush, out_valid, out_ready;
    logic        out_is_compressed, out_illegal;
    logic [31:0] in_pc, in_data, out_inst, out_pc, out_next_pc;

    always #5 clk = ~clk;

    rvc_expander dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_valid          (in_valid),
        .in_pc             (in_pc),
        .in_data           (in_data),
        .in_ready          (in_ready),
        .flush             (flush),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_inst          (out_inst),
        .out_pc            (out_pc),
        .out_next_pc       (out_next_pc),
        .out_is_compressed (out_is_compressed),
        .out_illegal       (out_illegal)
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] npc;
        logic        is_c;
        logic        ill;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    function automatic int fld(input int c, input int hi, input int lo);
        return (c >> lo) & ((1 << (hi - lo + 1)) - 1);
    endfunction

    function automatic int sx(input int v, input int bits);
        return (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
    endfunction

    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd, input int op);
        logic [31:0] r;
        r = 32'(f7) << 25 | 32'(rs2) << 20 | 32'(rs1) << 15 | 32'(f3) << 12 | 32'(rd) << 7 | 32'(op);
        return r;
    endfunction

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input int op);
        logic [31:0] u;
        u = imm;
        return (u & 32'hfff) << 20 | 32'(rs1) << 15 | 32'(f3) << 12 | 32'(rd) << 7 | 32'(op);
    endfunction

    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3);
        logic [31:0] u;
        u = imm;
        return ((u >> 5) & 32'h7f) << 25 | 32'(rs2) << 20 | 32'(rs1) << 15 | 32'(f3) << 12
             | (u & 32'h1f) << 7 | 32'h23;
    endfunction

    function automatic logic [31:0] enc_b(input int imm, input int rs1, input int f3);
        logic [31:0] u;
        u = imm;
        return ((u >> 12) & 1) << 31 | ((u >> 5) & 32'h3f) << 25 | 32'(rs1) << 15 | 32'(f3) << 12
             | ((u >> 1) & 32'hf) << 8 | ((u >> 11) & 1) << 7 | 32'h63;
    endfunction

    function automatic logic [31:0] enc_j(input int imm, input int rd);
        logic [31:0] u;
        u = imm;
        return ((u >> 20) & 1) << 31 | ((u >> 1) & 32'h3ff) << 21 | ((u >> 11) & 1) << 20
             | ((u >> 12) & 32'hff) << 12 | 32'(rd) << 7 | 32'h6f;
    endfunction

    function automatic exp_t ref_model(input logic [31:0] w, input logic [31:0] pc);
        exp_t e;
        int c, q, f3, rd, rs2, rdp, rs1p, imm6, v;
        bit ill;
        e.pc   = pc;
        e.is_c = (w[1:0] != 2'b11);
        e.npc  = pc + (e.is_c ? 32'd2 : 32'd4);
        e.ill  = 1'b0;
        e.inst = w;
        if (!e.is_c) return e;
        c    = int'(w[15:0]);
        q    = fld(c, 1, 0);
        f3   = fld(c, 15, 13);
        rd   = fld(c, 11, 7);
        rs2  = fld(c, 6, 2);
        rdp  = 8 + fld(c, 4, 2);
        rs1p = 8 + fld(c, 9, 7);
        imm6 = sx(fld(c, 12, 12) * 32 + fld(c, 6, 2), 6);
        ill  = 0;
        e.inst = 32'h13;
        case (q * 8 + f3)
            0: begin
                v = fld(c, 12, 11) * 16 + fld(c, 10, 7) * 64 + fld(c, 6, 6) * 4 + fld(c, 5, 5) * 8;
                if (v == 0) ill = 1; else e.inst = enc_i(v, 2, 0, rdp, 'h13);
            end
            2: e.inst = enc_i(fld(c, 12, 10) * 8 + fld(c, 6, 6) * 4 + fld(c, 5, 5) * 64, rs1p, 2, rdp, 'h03);
            6: e.inst = enc_s(fld(c, 12, 10) * 8 + fld(c, 6, 6) * 4 + fld(c, 5, 5) * 64, rdp, rs1p, 2);
            8: e.inst = enc_i(imm6, rd, 0, rd, 'h13);
            9, 13: begin
                v = sx(fld(c, 12, 12) * 2048 + fld(c, 11, 11) * 16 + fld(c, 10, 9) * 256 + fld(c, 8, 8) * 1024
                     + fld(c, 7, 7) * 64 + fld(c, 6, 6) * 128 + fld(c, 5, 3) * 2 + fld(c, 2, 2) * 32, 12);
                e.inst = enc_j(v, (f3 == 1) ? 1 : 0);
            end
            10: e.inst = enc_i(imm6, 0, 0, rd, 'h13);
            11: begin
                if (rd == 2) begin
                    v = sx(fld(c, 12, 12) * 512 + fld(c, 6, 6) * 16 + fld(c, 5, 5) * 64
                         + fld(c, 4, 3) * 128 + fld(c, 2, 2) * 32, 10);
                    if (v == 0) ill = 1; else e.inst = enc_i(v, 2, 0, 2, 'h13);
                end else begin
                    if (imm6 == 0) ill = 1;
                    else e.inst = ((32'(imm6) & 32'hfffff) << 12) | 32'(rd) << 7 | 32'h37;
                end
            end
            12: begin
                v = fld(c, 12, 12) * 32 + fld(c, 6, 2);
                case (fld(c, 11, 10))
                    0: if (v >= 32) ill = 1; else e.inst = enc_i(v, rs1p, 5, rs1p, 'h13);
                    1: if (v >= 32) ill = 1; else e.inst = enc_i(v + 'h400, rs1p, 5, rs1p, 'h13);
                    2: e.inst = enc_i(imm6, rs1p, 7, rs1p, 'h13);
                    default: begin
                        if (fld(c, 12, 12) == 1) ill = 1;
                        else case (fld(c, 6, 5))
                            0: e.inst = enc_r(32, rdp, rs1p, 0, rs1p, 'h33);
                            1: e.inst = enc_r(0, rdp, rs1p, 4, rs1p, 'h33);
                            2: e.inst = enc_r(0, rdp, rs1p, 6, rs1p, 'h33);
                            default: e.inst = enc_r(0, rdp, rs1p, 7, rs1p, 'h33);
                        endcase
                    end
                endcase
            end
            14, 15: begin
                v = sx(fld(c, 12, 12) * 256 + fld(c, 11, 10) * 8 + fld(c, 6, 5) * 64
                     + fld(c, 4, 3) * 2 + fld(c, 2, 2) * 32, 9);
                e.inst = enc_b(v, rs1p, (f3 == 6) ? 0 : 1);
            end
            16: if (fld(c, 12, 12) == 1) ill = 1; else e.inst = enc_i(rs2, rd, 1, rd, 'h13);
            18: begin
                if (rd == 0) ill = 1;
                else e.inst = enc_i(fld(c, 12, 12) * 32 + fld(c, 6, 4) * 4 + fld(c, 3, 2) * 64, 2, 2, rd, 'h03);
            end
            20: begin
                if (fld(c, 12, 12) == 0) begin
                    if (rs2 == 0) begin
                        if (rd == 0) ill = 1; else e.inst = enc_i(0, rd, 0, 0, 'h67);
                    end else e.inst = enc_r(0, rs2, 0, 0, rd, 'h33);
                end else begin
                    if (rs2 == 0) begin
                        if (rd == 0) e.inst = 32'h0010_0073; else e.inst = enc_i(0, rd, 0, 1, 'h67);
                    end else e.inst = enc_r(0, rs2, rd, 0, rd, 'h33);
                end
            end
            22: e.inst = enc_s(fld(c, 12, 9) * 4 + fld(c, 8, 7) * 64, rs2, 2, 2);
            default: ill = 1;
        endcase
        e.ill = ill;
        if (ill) e.inst = 32'h0000_0013;
        return e;
    endfunction

    // One clock: drive inputs at the falling edge, check in_ready, then check outputs after the rising edge.
    task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] d,
                        input logic ordy, input logic fl, input logic rst);
        bit   has, cons, ld;
        exp_t e;
        @(negedge clk);
        rst_n = !rst; in_valid = v; in_pc = pc; in_data = d; out_ready = ordy; flush = fl;
        #1;
        has = (exp_q.size() != 0);
        check_val("in_ready", 32'(in_ready), 32'(!has || ordy));
        cons = has && ordy;
        ld   = v && (!has || ordy);
        @(posedge clk);
        #1;
        if (rst || fl) begin
            exp_q.delete();
        end else begin
            if (cons) void'(exp_q.pop_front());
            if (ld) exp_q.push_back(ref_model(d, pc));
        end
        check_val("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            e = exp_q[0];
            check_val("out_inst", out_inst, e.inst);
            check_val("out_pc", out_pc, e.pc);
            check_val("out_next_pc", out_next_pc, e.npc);
            check_val("out_is_c", 32'(out_is_compressed), 32'(e.is_c));
            check_val("out_illegal", 32'(out_illegal), 32'(e.ill));
        end
    endtask

    logic [15:0] corner [12] = '{16'h0000, 16'h0004, 16'h6101, 16'h6081, 16'h4002, 16'h8002,
                                 16'h9002, 16'h1002, 16'h9CA1, 16'h0001, 16'h4001, 16'h8A06};

    initial begin
        logic [31:0] d;
        rst_n = 1'b0; in_valid = 1'b0; in_pc = '0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_valid", 32'(out_valid), 32'd0);
        check_val("rst_inst", out_inst, 32'h0000_0013);
        check_val("rst_pc", out_pc, 32'd0);
        check_val("rst_npc", out_next_pc, 32'd0);
        check_val("rst_is_c", 32'(out_is_compressed), 32'd0);
        check_val("rst_ill", 32'(out_illegal), 32'd0);

        step(1'b1, 32'h100, 32'h0000_4515, 1'b1, 1'b0, 1'b0);
        check_val("li_inst", out_inst, 32'h0050_0513);
        check_val("li_npc", out_next_pc, 32'h102);
        check_val("li_is_c", 32'(out_is_compressed), 32'd1);
        step(1'b1, 32'h102, 32'h0000_852E, 1'b1, 1'b0, 1'b0);
        check_val("mv_inst", out_inst, 32'h00B0_0533);
        step(1'b1, 32'h200, 32'h0000_41C8, 1'b1, 1'b0, 1'b0);
        check_val("lw_inst", out_inst, 32'h0045_A503);
        step(1'b1, 32'h104, 32'h00A5_8533, 1'b1, 1'b0, 1'b0);
        check_val("r32_inst", out_inst, 32'h00A5_8533);
        check_val("r32_npc", out_next_pc, 32'h108);
        check_val("r32_is_c", 32'(out_is_compressed), 32'd0);
        step(1'b1, 32'h300, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
        check_val("zero_ill", 32'(out_illegal), 32'd1);
        check_val("zero_inst", out_inst, 32'h0000_0013);
        check_val("zero_valid", 32'(out_valid), 32'd1);
        step(1'b1, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
        check_val("wrap_npc", out_next_pc, 32'h0);

        // Decode stalls for three cycles while the aligner keeps offering words.
        step(1'b1, 32'h400, 32'h0000_4515, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h404 + 32'(i * 2), 32'h0000_852E, 1'b0, 1'b0, 1'b0);
            check_val("hold_pc", out_pc, 32'h400);
        end
        step(1'b1, 32'h410, 32'h0000_852E, 1'b1, 1'b0, 1'b0);
        check_val("release_pc", out_pc, 32'h410);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        step(1'b1, 32'h500, 32'h0000_4515, 1'b1, 1'b1, 1'b0);
        check_val("flush_valid", 32'(out_valid), 32'd0);
        step(1'b1, 32'h600, 32'h0000_4515, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h604, 32'h0000_852E, 1'b1, 1'b0, 1'b1);
        check_val("midrst_valid", 32'(out_valid), 32'd0);
        check_val("midrst_inst", out_inst, 32'h0000_0013);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        foreach (corner[i]) step(1'b1, 32'h700 + 32'(i * 2), {16'h0000, corner[i]}, 1'b1, 1'b0, 1'b0);

        for (int n = 0; n < 4000; n++) begin
            d = $urandom;
            if ($urandom_range(0, 2) != 0) d[1:0] = 2'($urandom_range(0, 2));
            else d[1:0] = 2'b11;
            step($urandom_range(0, 3) != 0, $urandom & 32'hFFFF_FFFE, d,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0, $urandom_range(0, 255) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
